// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small decode helpers.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } muldiv_state_e;

  function automatic logic isSignedOp(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic isDivOp(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_negate.sv
// Combinational two's-complement conditional negate, used both to take operand
// magnitudes and to restore the sign of finished results.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring
// divide step per cycle on operand magnitudes, followed by a sign fix-up cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  muldiv_state_e    state_q, state_d;
  muldiv_op_e       op_q, op_d;
  logic             signA_q, signA_d, signB_q, signB_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] origA_q, origA_d, divisor_q, divisor_d;
  logic [WIDTH-1:0] accHi_q, accHi_d, accLo_q, accLo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  muldiv_op_e         opIn;
  logic               negA, negB;
  logic [WIDTH-1:0]   magA, magB, quoFix, remFix;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH:0]     mulSum, divTrial;

  assign opIn = muldiv_op_e'(Op);
  assign negA = isSignedOp(opIn) & OpA[WIDTH-1];
  assign negB = isSignedOp(opIn) & OpB[WIDTH-1];

  muldiv_negate #(.WIDTH(WIDTH))   uNegA    (.data_i(OpA), .neg_i(negA), .data_o(magA));
  muldiv_negate #(.WIDTH(WIDTH))   uNegB    (.data_i(OpB), .neg_i(negB), .data_o(magB));
  muldiv_negate #(.WIDTH(2*WIDTH)) uNegProd (.data_i({accHi_q, accLo_q}), .neg_i(signA_q ^ signB_q), .data_o(prodFix));
  muldiv_negate #(.WIDTH(WIDTH))   uNegQuo  (.data_i(accLo_q), .neg_i(signA_q ^ signB_q), .data_o(quoFix));
  muldiv_negate #(.WIDTH(WIDTH))   uNegRem  (.data_i(accHi_q), .neg_i(signA_q), .data_o(remFix));

  // The carry out of the multiply add shifts back into the product; a set top
  // bit of the divide trial means the subtraction borrowed and must be undone.
  assign mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, divisor_q} : '0);
  assign divTrial = {accHi_q, accLo_q[WIDTH-1]} - {1'b0, divisor_q};

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      divZero_q <= 1'b0;
      origA_q   <= '0;
      divisor_q <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      divZero_q <= divZero_d;
      origA_q   <= origA_d;
      divisor_q <= divisor_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    divZero_d = divZero_q;
    origA_d   = origA_q;
    divisor_d = divisor_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (HiWrite) hi_d = WriteData;
        if (LoWrite) lo_d = WriteData;
        if (Start) begin
          state_d   = ST_RUN;
          op_d      = opIn;
          signA_d   = negA;
          signB_d   = negB;
          divZero_d = (OpB == '0);
          origA_d   = OpA;
          divisor_d = magB;
          accHi_d   = '0;
          accLo_d   = magA;
          cnt_d     = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (isDivOp(op_q)) begin
          if (!divTrial[WIDTH]) begin
            accHi_d = divTrial[WIDTH-1:0];
            accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
          end else begin
            accHi_d = {accHi_q[WIDTH-2:0], accLo_q[WIDTH-1]};
            accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {accHi_d, accLo_d} = {mulSum, accLo_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_ITER) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        // A zero divisor reports the raw dividend rather than the fixed-up remainder.
        if (!isDivOp(op_q)) begin
          {hi_d, lo_d} = prodFix;
        end else if (divZero_q) begin
          hi_d  = origA_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = remFix;
          lo_d = quoFix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule
